ctrl_cfg_decoder: RTL and testbench



---
 rtl/ctrl_cfg_decoder_pkg.sv | 24 ++
 rtl/ctrl_cfg_decoder_if.sv | 14 +
 rtl/ctrl_cfg_decoder_sat_counter.sv | 21 ++
 rtl/ctrl_cfg_decoder.sv | 140 ++++++++++++++
 tb/tb_ctrl_cfg_decoder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_cfg_decoder_pkg.sv
// Shared definitions for the control-packet config decoder:
// header field offsets, FSM states and a saturating increment.
package ctrl_cfg_decoder_pkg;

  localparam int MOD_ID_LSB = 128;
  localparam int RES_ID_LSB = 136;
  localparam int IDX_LSB    = 144;
  localparam int MOD_ID_W   = 8;
  localparam int RES_ID_W   = 4;
  localparam int IDX_W      = 8;

  typedef enum logic [1:0] {
    BEAT0   = 2'd0,
    HDR     = 2'd1,
    WRITE   = 2'd2,
    DISCARD = 2'd3
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ctrl_cfg_decoder_if.sv
// Valid-only AXI-stream style bus carrying control packets.
interface ctrl_cfg_decoder_if #(
  parameter int DW = 256,
  parameter int UW = 128
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast);
  modport slave  (input  tdata, tkeep, tuser, tvalid, tlast);
endinterface

// File: rtl/ctrl_cfg_decoder_sat_counter.sv
// 16-bit saturating event counter with asynchronous active-low clear.
module sat_counter
  import ctrl_cfg_decoder_pkg::*;
(
  input  logic        clk_i,
  input  logic        clr_ni,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);
  logic [15:0] cnt_q, cnt_d;

  // Next count: bump on inc, hold at 16'hFFFF once reached.
  always_comb cnt_d = inc_i ? sat_inc(cnt_q) : cnt_q;

  // Count register, cleared with the block reset.
  always_ff @(posedge clk_i or negedge clr_ni)
    if (!clr_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

// File: rtl/ctrl_cfg_decoder.sv
// Control-packet decoder for one pipeline stage: forwards every beat one
// cycle later and turns payload beats of packets addressed to STAGE_ID
// into single-cycle table-write strobes.
module ctrl_cfg_decoder
  import ctrl_cfg_decoder_pkg::*;
#(
  parameter int         C_S_AXIS_DATA_WIDTH  = 256,
  parameter int         C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0] STAGE_ID             = 8'h00,
  parameter int         TBL_ADDR_W           = 5
) (
  input  logic                           clk,
  input  logic                           aresetn,
  ctrl_cfg_decoder_if.slave              ctrl_s_axis,
  ctrl_cfg_decoder_if.master             ctrl_m_axis,
  output logic                           cfg_wr_en,
  output logic [3:0]                     cfg_wr_res,
  output logic [TBL_ADDR_W-1:0]          cfg_wr_addr,
  output logic [C_S_AXIS_DATA_WIDTH-1:0] cfg_wr_data,
  output logic [15:0]                    stat_hit_cnt,
  output logic [15:0]                    stat_err_cnt
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;
  // One spare MSB so running past the last table entry is visible.
  localparam int IW = TBL_ADDR_W + 1;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [RES_ID_W-1:0]   res_q, res_d;
  logic                  wr_fire, hit_inc, err_inc;

  logic                  vld, last;
  logic [MOD_ID_W-1:0]   mod_id;
  logic [RES_ID_W-1:0]   res_id;
  logic [IDX_W-1:0]      start_idx;
  logic                  mod_hit, idx_ok;

  assign vld       = ctrl_s_axis.tvalid;
  assign last      = ctrl_s_axis.tlast;
  assign mod_id    = ctrl_s_axis.tdata[MOD_ID_LSB +: MOD_ID_W];
  assign res_id    = ctrl_s_axis.tdata[RES_ID_LSB +: RES_ID_W];
  assign start_idx = ctrl_s_axis.tdata[IDX_LSB +: IDX_W];
  assign mod_hit   = (mod_id == STAGE_ID);
  assign idx_ok    = int'(start_idx) < (1 << TBL_ADDR_W);

  // FSM state register.
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) state_q <= BEAT0;
    else          state_q <= state_d;

  // FSM next state; only valid beats move it, tlast always returns to BEAT0.
  always_comb begin
    state_d = state_q;
    if (vld) begin
      case (state_q)
        BEAT0:   state_d = last ? BEAT0 : HDR;
        HDR:     state_d = last ? BEAT0 : ((mod_hit && idx_ok) ? WRITE : DISCARD);
        WRITE:   state_d = last ? BEAT0 : (idx_q[IW-1] ? DISCARD : WRITE);
        default: state_d = last ? BEAT0 : DISCARD;
      endcase
    end
  end

  // FSM outputs: write strobe, counter bumps and header/index updates.
  always_comb begin
    wr_fire = 1'b0;
    hit_inc = 1'b0;
    err_inc = 1'b0;
    idx_d   = idx_q;
    res_d   = res_q;
    case (state_q)
      BEAT0: err_inc = vld && last;
      HDR: if (vld) begin
        res_d   = res_id;
        idx_d   = IW'(start_idx);
        // A header-only packet still counts as a hit but never as an error.
        hit_inc = mod_hit && (last || idx_ok);
        err_inc = mod_hit && !idx_ok && !last;
      end
      WRITE: if (vld) begin
        wr_fire = !idx_q[IW-1];
        err_inc = idx_q[IW-1];
        if (!idx_q[IW-1]) idx_d = idx_q + IW'(1);
      end
      default: ;
    endcase
  end

  // Latched header fields and running table index.
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      idx_q <= '0;
      res_q <= '0;
    end else begin
      idx_q <= idx_d;
      res_q <= res_d;
    end

  logic [DW-1:0]   fwd_tdata_q;
  logic [DW/8-1:0] fwd_tkeep_q;
  logic [UW-1:0]   fwd_tuser_q;
  logic            fwd_tvalid_q, fwd_tlast_q;

  // Forward register and write port, both one cycle behind the input beat.
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      fwd_tdata_q  <= '0;
      fwd_tkeep_q  <= '0;
      fwd_tuser_q  <= '0;
      fwd_tvalid_q <= 1'b0;
      fwd_tlast_q  <= 1'b0;
      cfg_wr_en    <= 1'b0;
      cfg_wr_res   <= '0;
      cfg_wr_addr  <= '0;
      cfg_wr_data  <= '0;
    end else begin
      fwd_tdata_q  <= ctrl_s_axis.tdata;
      fwd_tkeep_q  <= ctrl_s_axis.tkeep;
      fwd_tuser_q  <= ctrl_s_axis.tuser;
      fwd_tvalid_q <= ctrl_s_axis.tvalid;
      fwd_tlast_q  <= ctrl_s_axis.tlast;
      cfg_wr_en    <= wr_fire;
      if (wr_fire) begin
        cfg_wr_res  <= res_q;
        cfg_wr_addr <= idx_q[TBL_ADDR_W-1:0];
        cfg_wr_data <= ctrl_s_axis.tdata;
      end
    end

  assign ctrl_m_axis.tdata  = fwd_tdata_q;
  assign ctrl_m_axis.tkeep  = fwd_tkeep_q;
  assign ctrl_m_axis.tuser  = fwd_tuser_q;
  assign ctrl_m_axis.tvalid = fwd_tvalid_q;
  assign ctrl_m_axis.tlast  = fwd_tlast_q;

  sat_counter u_hit_cnt (.clk_i(clk), .clr_ni(aresetn), .inc_i(hit_inc), .cnt_o(stat_hit_cnt));
  sat_counter u_err_cnt (.clk_i(clk), .clr_ni(aresetn), .inc_i(err_inc), .cnt_o(stat_err_cnt));

endmodule

// File: tb/tb_ctrl_cfg_decoder.sv
// Bench for ctrl_cfg_decoder: table of directed packets, hand-written
// back-to-back and mid-packet reset sequences, then random packets checked
// against a packet-level reference model.
module tb_ctrl_cfg_decoder;
  localparam int         DW    = 256;
  localparam int         UW    = 128;
  localparam int         AW    = 5;
  localparam logic [7:0] STAGE = 8'h03;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  ctrl_cfg_decoder_if #(.DW(DW), .UW(UW)) s_if ();
  ctrl_cfg_decoder_if #(.DW(DW), .UW(UW)) m_if ();

  logic          cfg_wr_en;
  logic [3:0]    cfg_wr_res;
  logic [AW-1:0] cfg_wr_addr;
  logic [DW-1:0] cfg_wr_data;
  logic [15:0]   stat_hit_cnt, stat_err_cnt;

  ctrl_cfg_decoder #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW),
    .STAGE_ID(STAGE), .TBL_ADDR_W(AW)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .ctrl_s_axis(s_if), .ctrl_m_axis(m_if),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_res(cfg_wr_res), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .stat_hit_cnt(stat_hit_cnt), .stat_err_cnt(stat_err_cnt)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    res;
  } wr_t;

  typedef struct {
    logic [7:0] mod;
    logic [3:0] res;
    logic [7:0] idx;
    int         nbeats;
    bit         gaps;
    int         nwr;
    int         dhit;
    int         derr;
  } vec_t;

  int  checks = 0;
  int  errors = 0;
  int  wr_seen = 0;
  int  exp_hit = 0, exp_err = 0;   // reference-model counters
  bit  chk_en = 1'b0;
  wr_t wq[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  // Packet-level reference: counters and expected writes from the header rules.
  task automatic model_pkt(input logic [7:0] mod, input logic [3:0] res, input logic [7:0] idx,
                           input logic [DW-1:0] beats[$]);
    int  n;
    bit  ovf;
    wr_t w;
    n = beats.size();
    if (n == 1) exp_err++;
    else if (mod == STAGE) begin
      if (n == 2) exp_hit++;
      else if (int'(idx) < (1 << AW)) begin
        exp_hit++;
        ovf = 1'b0;
        for (int p = 0; p < n - 2; p++) begin
          if (int'(idx) + p < (1 << AW)) begin
            w.addr = AW'(int'(idx) + p);
            w.data = beats[p+2];
            w.res  = res;
            wq.push_back(w);
          end else ovf = 1'b1;
        end
        if (ovf) exp_err++;
      end else exp_err++;
    end
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic last);
    @(posedge clk); #1;
    s_if.tdata  = d;
    s_if.tkeep  = $urandom;
    s_if.tuser  = {$urandom, $urandom, $urandom, $urandom};
    s_if.tvalid = 1'b1;
    s_if.tlast  = last;
  endtask

  // Idle cycles carry junk data/tlast with tvalid low; the decoder must ignore them.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s_if.tdata  = rnd_data();
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_pkt(input logic [7:0] mod, input logic [3:0] res, input logic [7:0] idx,
                          input int nbeats, input bit gaps);
    logic [DW-1:0] beats[$];
    logic [DW-1:0] b;
    for (int i = 0; i < nbeats; i++) begin
      b = rnd_data();
      if (i == 1) begin
        b[135:128] = mod;
        b[139:136] = res;
        b[151:144] = idx;
      end
      beats.push_back(b);
    end
    model_pkt(mod, res, idx, beats);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && i >= 2) idle($urandom_range(1, 2));
      drive_beat(beats[i], 1'(i == nbeats - 1));
    end
  endtask

  // Expected forward beat: whatever sat on the input at the last edge.
  logic [417:0] ef;
  always @(posedge clk)
    ef <= {s_if.tvalid, s_if.tlast, s_if.tkeep, s_if.tuser, s_if.tdata};

  // Monitor: forward path every cycle, writes against the expected queue.
  always @(negedge clk) begin
    wr_t w;
    if (chk_en) begin
      chk("fwd", 512'({m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tuser, m_if.tdata}), 512'(ef));
      if (cfg_wr_en) begin
        wr_seen++;
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%0d expected no write", cfg_wr_addr);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", 512'(cfg_wr_addr), 512'(w.addr));
          chk("wr_data", 512'(cfg_wr_data), 512'(w.data));
          chk("wr_res",  512'(cfg_wr_res),  512'(w.res));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"},  512'(cfg_wr_en), 512'(0));
    chk({tag, "_wr_bus"}, 512'({cfg_wr_res, cfg_wr_addr, cfg_wr_data}), 512'(0));
    chk({tag, "_fwd"},    512'({m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tuser, m_if.tdata}), 512'(0));
    chk({tag, "_cnt"},    512'({stat_hit_cnt, stat_err_cnt}), 512'(0));
  endtask

  vec_t tbl[12];
  int   tab_hit = 0, tab_err = 0;

  initial begin
    int wr0;
    logic [DW-1:0] d;
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0;
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;

    //          mod    res   idx    nb gap  nwr hit err
    tbl[0]  = '{8'h03, 4'h2, 8'd4,  5, 0,   3,  1,  0};  // basic 3-entry write
    tbl[1]  = '{8'h07, 4'h2, 8'd4,  5, 0,   0,  0,  0};  // other stage
    tbl[2]  = '{8'h03, 4'h1, 8'd30, 6, 0,   2,  1,  1};  // runs off the table end
    tbl[3]  = '{8'h03, 4'h0, 8'd0,  1, 0,   0,  0,  1};  // single-beat packet
    tbl[4]  = '{8'h03, 4'h5, 8'd9,  2, 0,   0,  1,  0};  // header only, match
    tbl[5]  = '{8'h09, 4'h5, 8'd9,  2, 0,   0,  0,  0};  // header only, no match
    tbl[6]  = '{8'h03, 4'h4, 8'd40, 4, 0,   0,  0,  1};  // start out of range
    tbl[7]  = '{8'h03, 4'h6, 8'd31, 3, 0,   1,  1,  0};  // last entry exactly
    tbl[8]  = '{8'h03, 4'h7, 8'd32, 3, 0,   0,  0,  1};  // first illegal start
    tbl[9]  = '{8'h03, 4'h8, 8'd31, 4, 0,   1,  1,  1};  // one past the end
    tbl[10] = '{8'h03, 4'h2, 8'd4,  5, 1,   3,  1,  0};  // same as 0 with gaps
    tbl[11] = '{8'h03, 4'h9, 8'd0,  3, 1,   1,  1,  0};  // gapped, address 0

    // Reset state
    repeat (3) @(posedge clk);
    #2 chk_all_zero("reset");
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk); #1 chk_en = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      wr0 = wr_seen;
      send_pkt(tbl[i].mod, tbl[i].res, tbl[i].idx, tbl[i].nbeats, tbl[i].gaps);
      idle(3);
      tab_hit += tbl[i].dhit;
      tab_err += tbl[i].derr;
      chk($sformatf("tbl%0d_nwr", i), 512'(wr_seen - wr0), 512'(tbl[i].nwr));
      chk($sformatf("tbl%0d_hit", i), 512'(stat_hit_cnt), 512'(sat16(tab_hit)));
      chk($sformatf("tbl%0d_err", i), 512'(stat_err_cnt), 512'(sat16(tab_err)));
    end

    // Back-to-back packets with no idle between them
    wr0 = wr_seen;
    send_pkt(8'h03, 4'h2, 8'd4, 5, 0);
    send_pkt(8'h03, 4'h0, 8'd0, 1, 0);
    send_pkt(8'h03, 4'h3, 8'd30, 6, 0);
    send_pkt(8'h03, 4'hA, 8'd10, 4, 0);
    idle(3);
    chk("b2b_nwr", 512'(wr_seen - wr0), 512'(7));
    chk("b2b_hit", 512'(stat_hit_cnt), 512'(sat16(exp_hit)));
    chk("b2b_err", 512'(stat_err_cnt), 512'(sat16(exp_err)));
    chk("b2b_wq_empty", 512'(wq.size()), 512'(0));

    // Reset asserted while a write is on the output
    chk_en = 1'b0;
    drive_beat(rnd_data(), 1'b0);
    d = rnd_data();
    d[135:128] = STAGE; d[139:136] = 4'h5; d[151:144] = 8'd10;
    drive_beat(d, 1'b0);
    drive_beat(rnd_data(), 1'b0);
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    chk("mid_wr_en", 512'(cfg_wr_en), 512'(1));
    chk("mid_wr_addr", 512'(cfg_wr_addr), 512'(10));
    #2 aresetn = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk) aresetn = 1'b1;
    wq.delete();
    exp_hit = 0; exp_err = 0;
    @(posedge clk); #1 chk_en = 1'b1;
    wr0 = wr_seen;
    send_pkt(8'h03, 4'h2, 8'd4, 5, 0);
    idle(3);
    chk("post_rst_nwr", 512'(wr_seen - wr0), 512'(3));
    chk("post_rst_hit", 512'(stat_hit_cnt), 512'(1));
    chk("post_rst_err", 512'(stat_err_cnt), 512'(0));

    // Random packets against the reference model
    for (int n = 0; n < 60; n++) begin
      send_pkt($urandom_range(0, 1) ? STAGE : 8'($urandom_range(0, 255)),
               4'($urandom_range(0, 15)), 8'($urandom_range(0, 40)),
               $urandom_range(1, 7), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    chk("rand_hit", 512'(stat_hit_cnt), 512'(sat16(exp_hit)));
    chk("rand_err", 512'(stat_err_cnt), 512'(sat16(exp_err)));
    chk("rand_wq_empty", 512'(wq.size()), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
